// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file: buffers (addr, data) requests,
// drains one per cycle into the write port and forwards the newest pending value.
module regfile_wb_queue #(
  parameter int DW    = 16,
  parameter int AW    = 3,
  parameter int DEPTH = 4
) (
  input  logic          Clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          wr_stall,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rs_addr,
  output logic          rs_hit,
  output logic [DW-1:0] rs_data,
  input  logic [AW-1:0] rt_addr,
  output logic          rt_hit,
  output logic [DW-1:0] rt_data,
  output logic [AW:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]    q_addr [DEPTH];
  logic [DW-1:0]    q_data [DEPTH];
  logic [DEPTH-1:0] q_valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [AW:0]      cnt;
  logic             push;
  logic             pop;

  // Register 0 is hardwired zero, so its writes complete the handshake but are dropped.
  assign in_ready = ~reset & (cnt != FULL);
  assign push     = in_valid & in_ready & (in_addr != '0);
  assign pop      = ~reset & (cnt != '0) & ~wr_stall;

  assign wr_en   = pop;
  assign wr_addr = pop ? q_addr[head] : '0;
  assign wr_data = pop ? q_data[head] : '0;
  assign count   = cnt;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      cnt     <= '0;
      q_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (push) begin
        q_addr[tail]  <= in_addr;
        q_data[tail]  <= in_data;
        q_valid[tail] <= 1'b1;
        tail          <= tail + PW'(1);
      end
      if (pop) begin
        q_valid[head] <= 1'b0;
        head          <= head + PW'(1);
      end
      if (push && !pop) begin
        cnt <= cnt + (AW+1)'(1);
      end else if (pop && !push) begin
        cnt <= cnt - (AW+1)'(1);
      end
    end
  end

  // Walk oldest to newest so the last match (closest to tail) wins.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
    logic [PW-1:0] idx;
    logic [DW:0]   r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (q_valid[idx] && (q_addr[idx] == a) && (a != '0)) begin
        r = {1'b1, q_data[idx]};
      end
    end
    return r;
  endfunction

  assign {rs_hit, rs_data} = lookup(rs_addr);
  assign {rt_hit, rt_data} = lookup(rt_addr);

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: table-driven vectors with a scoreboard
// of pending writes, plus hand-written asynchronous reset sequences.
module tb_regfile_wb_queue;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 4;

  logic          Clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          wr_stall;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rs_addr;
  logic          rs_hit;
  logic [DW-1:0] rs_data;
  logic [AW-1:0] rt_addr;
  logic          rt_hit;
  logic [DW-1:0] rt_data;
  logic [AW:0]   count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  regfile_wb_queue #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
    .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs_addr(rs_addr), .rs_hit(rs_hit), .rs_data(rs_data),
    .rt_addr(rt_addr), .rt_hit(rt_hit), .rt_data(rt_data),
    .count(count)
  );

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          stall;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          ready;
    logic          wren;
    logic [AW:0]   cnt;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  vec_t vecs[$];
  ent_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Newest pending write to address a, from the scoreboard.
  function automatic logic [DW:0] fwd(input logic [AW-1:0] a);
    logic [DW:0] r;
    r = '0;
    if (a != '0) begin
      foreach (sb[i]) if (sb[i].a == a) r = {1'b1, sb[i].d};
    end
    return r;
  endfunction

  task automatic checkOutput(input vec_t t, input int n);
    logic [DW:0] e;
    string       tag;
    tag = $sformatf("v%0d", n);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(t.ready));
    check({tag, ".wr_en"},    32'(wr_en),    32'(t.wren));
    check({tag, ".count"},    32'(count),    32'(t.cnt));
    if (t.wren && sb.size() > 0) begin
      check({tag, ".wr_addr"}, 32'(wr_addr), 32'(sb[0].a));
      check({tag, ".wr_data"}, 32'(wr_data), 32'(sb[0].d));
    end else begin
      check({tag, ".wr_addr"}, 32'(wr_addr), 32'(0));
      check({tag, ".wr_data"}, 32'(wr_data), 32'(0));
    end
    e = fwd(t.rs);
    check({tag, ".rs"}, {15'd0, rs_hit, rs_data}, {15'd0, e});
    e = fwd(t.rt);
    check({tag, ".rt"}, {15'd0, rt_hit, rt_data}, {15'd0, e});
  endtask

  // Called at posedge+1: drive, check combinational view, then advance the model at the edge.
  task automatic applyStimulus(input vec_t t, input int n);
    logic do_push, do_pop;
    in_valid = t.v;
    in_addr  = t.a;
    in_data  = t.d;
    wr_stall = t.stall;
    rs_addr  = t.rs;
    rt_addr  = t.rt;
    #1;
    checkOutput(t, n);
    do_push = t.v & t.ready & (t.a != '0);
    do_pop  = t.wren;
    @(posedge Clk);
    if (do_pop && sb.size() > 0) void'(sb.pop_front());
    if (do_push) sb.push_back('{t.a, t.d});
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(0));
    check({tag, ".wr_en"},    32'(wr_en),    32'(0));
    check({tag, ".wr_addr"},  32'(wr_addr),  32'(0));
    check({tag, ".wr_data"},  32'(wr_data),  32'(0));
    check({tag, ".rs"},       {15'd0, rs_hit, rs_data}, 32'(0));
    check({tag, ".rt"},       {15'd0, rt_hit, rt_data}, 32'(0));
    check({tag, ".count"},    32'(count),    32'(0));
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 3'd3;
    in_data  = 16'h1234;
    wr_stall = 1'b0;
    rs_addr  = 3'd3;
    rt_addr  = 3'd3;
    #2;
    checkAllZero("por");
    in_valid = 1'b0;
    repeat (2) @(posedge Clk);
    #3 reset = 1'b0;
    @(posedge Clk); #1;
    check("rel.in_ready", 32'(in_ready), 32'(1));
    check("rel.count",    32'(count),    32'(0));

    // One queued entry, then asynchronous reset in the middle of the cycle.
    in_valid = 1'b1; in_addr = 3'd3; in_data = 16'h1234; wr_stall = 1'b1;
    @(posedge Clk); #1;
    in_valid = 1'b0;
    #1;
    check("pre.count", 32'(count), 32'(1));
    check("pre.rs",    {15'd0, rs_hit, rs_data}, {15'd0, 1'b1, 16'h1234});
    #1 reset = 1'b1;
    #1 checkAllZero("async");
    #1 reset = 1'b0;
    wr_stall = 1'b0;
    @(posedge Clk); #1;
    check("post.in_ready", 32'(in_ready), 32'(1));
    check("post.count",    32'(count),    32'(0));
    check("post.wr_en",    32'(wr_en),    32'(0));

    //               v   a     d        st  rs    rt    rdy wen cnt
    vecs.push_back('{1, 3'd3, 16'hBEEF, 0, 3'd3, 3'd0, 1, 0, 4'd0});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd3, 3'd3, 1, 1, 4'd1});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd3, 3'd0, 1, 0, 4'd0});
    vecs.push_back('{1, 3'd1, 16'h0011, 1, 3'd1, 3'd4, 1, 0, 4'd0});
    vecs.push_back('{1, 3'd2, 16'h0022, 1, 3'd1, 3'd4, 1, 0, 4'd1});
    vecs.push_back('{1, 3'd3, 16'h0033, 1, 3'd1, 3'd4, 1, 0, 4'd2});
    vecs.push_back('{1, 3'd4, 16'h0044, 1, 3'd1, 3'd4, 1, 0, 4'd3});
    vecs.push_back('{1, 3'd5, 16'h0055, 1, 3'd1, 3'd4, 0, 0, 4'd4});
    vecs.push_back('{1, 3'd5, 16'h0055, 0, 3'd1, 3'd5, 0, 1, 4'd4});
    vecs.push_back('{1, 3'd5, 16'h0055, 0, 3'd2, 3'd5, 1, 1, 4'd3});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd3, 3'd5, 1, 1, 4'd3});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd4, 3'd5, 1, 1, 4'd2});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd5, 3'd5, 1, 1, 4'd1});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd5, 3'd5, 1, 0, 4'd0});
    vecs.push_back('{1, 3'd2, 16'h1111, 1, 3'd0, 3'd2, 1, 0, 4'd0});
    vecs.push_back('{1, 3'd2, 16'h2222, 1, 3'd0, 3'd2, 1, 0, 4'd1});
    vecs.push_back('{0, 3'd0, 16'h0000, 1, 3'd0, 3'd2, 1, 0, 4'd2});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd0, 3'd2, 1, 1, 4'd2});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd0, 3'd2, 1, 1, 4'd1});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd0, 3'd2, 1, 0, 4'd0});
    vecs.push_back('{1, 3'd0, 16'hFFFF, 0, 3'd0, 3'd0, 1, 0, 4'd0});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd0, 3'd0, 1, 0, 4'd0});
    vecs.push_back('{1, 3'd6, 16'h0066, 1, 3'd3, 3'd1, 1, 0, 4'd0});
    vecs.push_back('{1, 3'd7, 16'h0077, 1, 3'd3, 3'd1, 1, 0, 4'd1});
    vecs.push_back('{1, 3'd1, 16'h0101, 0, 3'd3, 3'd1, 1, 1, 4'd2});
    vecs.push_back('{1, 3'd2, 16'h0202, 0, 3'd3, 3'd1, 1, 1, 4'd2});
    vecs.push_back('{1, 3'd3, 16'h0303, 0, 3'd3, 3'd1, 1, 1, 4'd2});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd3, 3'd2, 1, 1, 4'd2});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd3, 3'd2, 1, 1, 4'd1});
    vecs.push_back('{0, 3'd0, 16'h0000, 0, 3'd3, 3'd2, 1, 0, 4'd0});
    // Three pending entries for the reset-mid-drain sequence.
    vecs.push_back('{1, 3'd4, 16'h0404, 1, 3'd5, 3'd4, 1, 0, 4'd0});
    vecs.push_back('{1, 3'd5, 16'h0505, 1, 3'd5, 3'd4, 1, 0, 4'd1});
    vecs.push_back('{1, 3'd6, 16'h0606, 1, 3'd5, 3'd4, 1, 0, 4'd2});

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    in_valid = 1'b0;
    wr_stall = 1'b0;
    rs_addr  = 3'd5;
    #1;
    check("drain.wr_en",   32'(wr_en),   32'(1));
    check("drain.wr_addr", 32'(wr_addr), 32'(4));
    check("drain.count",   32'(count),   32'(3));
    #1 reset = 1'b1;
    #1;
    check("mid.wr_en",   32'(wr_en),   32'(0));
    check("mid.wr_addr", 32'(wr_addr), 32'(0));
    check("mid.count",   32'(count),   32'(0));
    check("mid.rs_hit",  32'(rs_hit),  32'(0));
    sb.delete();
    #2 reset = 1'b0;
    @(posedge Clk); #1;
    for (int i = 0; i < 4; i++) begin
      vec_t t;
      t = '{0, 3'd0, 16'h0000, 0, 3'd5, 3'd6, 1, 0, 4'd0};
      applyStimulus(t, 100 + i);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writer-side front end for the 16-bit register file: buffers pipeline write-back requests (address, data) and drains them into the register file write port, one per cycle.
- Gives the decode stage forwarding lookups, so a register with a pending write is read with its newest queued value.
- Sits between the write-back stage and the register file built from the 16-bit D_FF registers.

Parameters:
- DW, 16, data width of one register.
- AW, 3, register address width (2^AW architectural registers).
- DEPTH, 4, queue entries (power of two, >= 2).

Ports:
- Clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  write-back request present.
- in_addr  input  AW  destination register.
- in_data  input  DW  write-back value.
- in_ready  output  1  queue can accept a request this cycle.
- wr_stall  input  1  register file cannot accept a write this cycle.
- wr_en  output  1  register file write enable.
- wr_addr  output  AW  register file write address.
- wr_data  output  DW  register file write data.
- rs_addr  input  AW  forwarding lookup A address.
- rs_hit  output  1  lookup A matches a queued entry.
- rs_data  output  DW  newest queued data for rs_addr.
- rt_addr  input  AW  forwarding lookup B address.
- rt_hit  output  1  lookup B matches a queued entry.
- rt_data  output  DW  newest queued data for rt_addr.
- count  output  AW+1  number of occupied entries (0..DEPTH).

Behaviour:
- Reset (async, active-high):
  - Clears head and tail pointers and count, and all entry valid bits.
  - While reset is high: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, rs_hit=rt_hit=0, rs_data=rt_data=0, count=0.
  - Reset asserted mid-operation discards all pending writes immediately; no further wr_en is issued for them.
- Accept:
  - in_ready = ~reset & (count != DEPTH). It depends only on full; there is no same-cycle pass-through when full.
  - A push occurs on a Clk edge where in_valid & in_ready.
  - in_addr==0 is accepted (handshake completes) but is not enqueued, because register 0 is hardwired zero.
- Drain:
  - wr_en = (count != 0) & ~wr_stall. wr_addr and wr_data show the head entry combinationally.
  - Head pops on the same edge the register file captures. When wr_en=0, wr_addr and wr_data read 0.
- Simultaneous push and pop: count is unchanged and both pointers advance. When count==DEPTH, no push occurs even if a pop happens that cycle.
- Pointers wrap modulo DEPTH. FIFO order is strict.
- Latency: a request pushed at edge N appears on wr_en at the earliest in cycle N+1 (after edge N) if the queue was empty.
- Forwarding (combinational):
  - A hit is defined over all valid entries, including the head being drained this cycle.
  - When several entries match, the newest (closest to tail) wins.
  - Address 0 never hits; on a miss the data output is 0.
  - The incoming in_data of the current cycle is not forwarded.
- count increments on a push-only cycle, decrements on a pop-only cycle, and never exceeds DEPTH or underflows.

Test Plan:
- Reset then idle:
  - Assert reset mid-cycle (asynchronously).
  - Required: all outputs 0 immediately.
  - Release reset: in_ready=1, count=0.
- Single write:
  - Push (addr=3, data=16'hBEEF).
  - Required next cycle: wr_en=1, wr_addr=3, wr_data=BEEF, rs_addr=3 gives rs_hit=1/BEEF.
  - Required after that: count=0, wr_en=0.
- Fill and back-pressure:
  - Hold wr_stall=1 and push 5 requests (addr 1..5, data 16'h0011..16'h0055).
  - Required: first 4 accepted, count=4, in_ready=0, fifth request held.
  - Release wr_stall: writes 1..4 drain in order on consecutive cycles, then 5 is accepted.
- Forwarding priority:
  - With wr_stall=1, queue (addr=2, 16'h1111) then (addr=2, 16'h2222).
  - Required: rt_addr=2 gives rt_hit=1, rt_data=2222.
  - Required: after one drain, still 2222; after the second drain, rt_hit=0.
- Register 0 and simultaneous push/pop:
  - Push addr=0 with data FFFF.
  - Required: handshake completes, count unchanged, no wr_en.
  - With count=2, push and pop on the same edge: required count stays 2 and FIFO order is preserved across pointer wrap.
- Reset mid-drain:
  - With 3 entries pending and wr_en=1, assert reset.
  - Required: wr_en drops to 0 immediately and count=0.
  - Required after release: no stale writes.
